// File: rtl/wb_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_cmd_master                                                   |
// | Purpose  : Wishbone classic single-transfer bus master. Converts one       |
// |            valid/ready command into one read or write cycle and returns    |
// |            data plus err/timeout status on a valid/ready response port.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255   // 0 disables the bus timeout; max 65535
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // Wishbone master side
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // Counter value on the last permitted bus cycle; cyc is then high for TIMEOUT cycles.
  localparam logic        C_TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] C_TMO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        w_done;

  // Next-state logic: accept a command, watch for termination, hold the response.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    we_d          = we_q;
    sel_d         = sel_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_dat_d     = rsp_dat_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    w_done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_d   = 16'd0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + 16'd1;
        // Error beats ack, and either beats the timeout on the expiry cycle.
        if (wb_err_i) begin
          w_done    = 1'b1;
          rsp_err_d = 1'b1;
          rsp_dat_d = 32'd0;
        end else if (wb_ack_i) begin
          w_done    = 1'b1;
          rsp_dat_d = we_q ? 32'd0 : wb_dat_i;
        end else if (C_TMO_EN && (cnt_q == C_TMO_LAST)) begin
          w_done        = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_dat_d     = 32'd0;
        end
        if (w_done) begin
          cyc_d       = 1'b0;
          cnt_d       = 16'd0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any cycle in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= 4'd0;
      adr_q         <= 32'd0;
      dat_q         <= 32'd0;
      cnt_q         <= 16'd0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= 32'd0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_dat_q     <= rsp_dat_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;

endmodule
`default_nettype wire
